// File: rtl/tl_ul_to_apb.sv
// TileLink-UL (single beat) to APB4 bridge, one transfer outstanding at a time.
// A beat accepted in IDLE is either issued as an APB SETUP/ACCESS pair or, when it cannot be
// expressed on APB, answered directly with a denied response.
// Optional feature: define TL2APB_TIMEOUT_EN to abort ACCESS phases that see no pready after
// TIMEOUT cycles; without it ACCESS waits indefinitely and TIMEOUT is unused.
module tl_ul_to_apb #(
    parameter int unsigned TL_RS   = 4,
    parameter int unsigned TL_AW   = 28,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             tilelink_clock_i,
    input  logic             tilelink_reset_i,

    // TL-UL A channel
    input  logic [2:0]       tl_a_opcode,
    input  logic [2:0]       tl_a_param,
    input  logic [3:0]       tl_a_size,
    input  logic [TL_RS-1:0] tl_a_source,
    input  logic [TL_AW-1:0] tl_a_address,
    input  logic [3:0]       tl_a_mask,
    input  logic [31:0]      tl_a_data,
    input  logic             tl_a_corrupt,
    input  logic             tl_a_valid,
    output logic             tl_a_ready,

    // TL-UL D channel
    output logic [2:0]       tl_d_opcode,
    output logic [1:0]       tl_d_param,
    output logic [3:0]       tl_d_size,
    output logic [TL_RS-1:0] tl_d_source,
    output logic             tl_d_denied,
    output logic [31:0]      tl_d_data,
    output logic             tl_d_corrupt,
    output logic             tl_d_valid,
    input  logic             tl_d_ready,

    // APB requester
    output logic [TL_AW-1:0] apb_paddr,
    output logic             apb_psel,
    output logic             apb_penable,
    output logic             apb_pwrite,
    output logic [31:0]      apb_pwdata,
    output logic [3:0]       apb_pstrb,
    output logic [2:0]       apb_pprot,
    input  logic [31:0]      apb_prdata,
    input  logic             apb_pready,
    input  logic             apb_pslverr
);

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] OpAccessAck  = 3'd0;
    localparam logic [2:0] OpAckData    = 3'd1;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e state_q, state_d;

    // Request/response payload, latched on accept and updated on APB completion
    logic [TL_AW-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       strb_q, strb_d;
    logic             write_q, write_d;
    logic             get_q, get_d;
    logic [3:0]       size_q, size_d;
    logic [TL_RS-1:0] source_q, source_d;
    logic             denied_q, denied_d;
    logic [31:0]      rdata_q, rdata_d;

    logic a_accept;
    logic a_is_get;
    logic a_is_put;
    logic a_legal;

    // Ready only in IDLE, and never while reset is held
    assign tl_a_ready = (state_q == StIdle) && !tilelink_reset_i;
    assign a_accept   = tl_a_valid && tl_a_ready;

    assign a_is_get = (tl_a_opcode == OpGet);
    assign a_is_put = (tl_a_opcode == OpPutFull) || (tl_a_opcode == OpPutPartial);
    // Corrupt write data must never reach the peripheral
    assign a_legal  = (tl_a_size <= 4'd2) && (a_is_get || (a_is_put && !tl_a_corrupt));

`ifdef TL2APB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // ACCESS wait counter
    always_ff @(posedge tilelink_clock_i or posedge tilelink_reset_i) begin
        if (tilelink_reset_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
`endif

    // Only word-aligned APB accesses are issued; param carries no meaning for Get/Put
    logic unused_inputs;
    assign unused_inputs = ^{tl_a_param, tl_a_address[1:0]};

    // Next-state and payload update
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        write_d  = write_q;
        get_d    = get_q;
        size_d   = size_q;
        source_d = source_q;
        denied_d = denied_q;
        rdata_d  = rdata_q;
`ifdef TL2APB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (a_accept) begin
                    addr_d   = {tl_a_address[TL_AW-1:2], 2'b00};
                    wdata_d  = tl_a_data;
                    strb_d   = a_is_put ? tl_a_mask : 4'b0000;
                    write_d  = a_is_put;
                    get_d    = a_is_get;
                    size_d   = tl_a_size;
                    source_d = tl_a_source;
                    rdata_d  = 32'h0;
                    denied_d = !a_legal;
                    state_d  = a_legal ? StSetup : StResp;
                end
            end
            StSetup: begin
`ifdef TL2APB_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
                state_d = StAccess;
            end
            StAccess: begin
                if (apb_pready) begin
                    rdata_d  = get_q ? apb_prdata : 32'h0;
                    denied_d = apb_pslverr;
                    state_d  = StResp;
`ifdef TL2APB_TIMEOUT_EN
                end else if (cnt_q == TimeoutLast) begin
                    rdata_d  = 32'h0;
                    denied_d = 1'b1;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            StResp: begin
                if (tl_d_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge tilelink_clock_i or posedge tilelink_reset_i) begin
        if (tilelink_reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers; cleared by reset so every output reads 0 while reset is held
    always_ff @(posedge tilelink_clock_i or posedge tilelink_reset_i) begin
        if (tilelink_reset_i) begin
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            strb_q   <= 4'b0000;
            write_q  <= 1'b0;
            get_q    <= 1'b0;
            size_q   <= 4'd0;
            source_q <= '0;
            denied_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            write_q  <= write_d;
            get_q    <= get_d;
            size_q   <= size_d;
            source_q <= source_d;
            denied_q <= denied_d;
            rdata_q  <= rdata_d;
        end
    end

    // APB outputs: address phase fields come straight from the latched request
    assign apb_psel    = (state_q == StSetup) || (state_q == StAccess);
    assign apb_penable = (state_q == StAccess);
    assign apb_paddr   = addr_q;
    assign apb_pwrite  = write_q;
    assign apb_pwdata  = wdata_q;
    assign apb_pstrb   = strb_q;
    assign apb_pprot   = 3'b000;

    // D channel outputs
    assign tl_d_valid   = (state_q == StResp);
    assign tl_d_opcode  = get_q ? OpAckData : OpAccessAck;
    assign tl_d_param   = 2'b00;
    assign tl_d_size    = size_q;
    assign tl_d_source  = source_q;
    assign tl_d_denied  = denied_q;
    assign tl_d_data    = rdata_q;
    assign tl_d_corrupt = denied_q && get_q;

endmodule

// File: tb/tb_tl_ul_to_apb.sv
// Directed self-checking bench for tl_ul_to_apb (default parameters, TIMEOUT = 16).
module tb_tl_ul_to_apb;

    localparam int unsigned TL_RS = 4;
    localparam int unsigned TL_AW = 28;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       tl_a_opcode;
    logic [2:0]       tl_a_param;
    logic [3:0]       tl_a_size;
    logic [TL_RS-1:0] tl_a_source;
    logic [TL_AW-1:0] tl_a_address;
    logic [3:0]       tl_a_mask;
    logic [31:0]      tl_a_data;
    logic             tl_a_corrupt;
    logic             tl_a_valid;
    logic             tl_a_ready;
    logic [2:0]       tl_d_opcode;
    logic [1:0]       tl_d_param;
    logic [3:0]       tl_d_size;
    logic [TL_RS-1:0] tl_d_source;
    logic             tl_d_denied;
    logic [31:0]      tl_d_data;
    logic             tl_d_corrupt;
    logic             tl_d_valid;
    logic             tl_d_ready;
    logic [TL_AW-1:0] apb_paddr;
    logic             apb_psel;
    logic             apb_penable;
    logic             apb_pwrite;
    logic [31:0]      apb_pwdata;
    logic [3:0]       apb_pstrb;
    logic [2:0]       apb_pprot;
    logic [31:0]      apb_prdata;
    logic             apb_pready;
    logic             apb_pslverr;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    tl_ul_to_apb #(
        .TL_RS   (TL_RS),
        .TL_AW   (TL_AW),
        .TIMEOUT (16)
    ) dut (
        .tilelink_clock_i (clk),
        .tilelink_reset_i (rst),
        .tl_a_opcode      (tl_a_opcode),
        .tl_a_param       (tl_a_param),
        .tl_a_size        (tl_a_size),
        .tl_a_source      (tl_a_source),
        .tl_a_address     (tl_a_address),
        .tl_a_mask        (tl_a_mask),
        .tl_a_data        (tl_a_data),
        .tl_a_corrupt     (tl_a_corrupt),
        .tl_a_valid       (tl_a_valid),
        .tl_a_ready       (tl_a_ready),
        .tl_d_opcode      (tl_d_opcode),
        .tl_d_param       (tl_d_param),
        .tl_d_size        (tl_d_size),
        .tl_d_source      (tl_d_source),
        .tl_d_denied      (tl_d_denied),
        .tl_d_data        (tl_d_data),
        .tl_d_corrupt     (tl_d_corrupt),
        .tl_d_valid       (tl_d_valid),
        .tl_d_ready       (tl_d_ready),
        .apb_paddr        (apb_paddr),
        .apb_psel         (apb_psel),
        .apb_penable      (apb_penable),
        .apb_pwrite       (apb_pwrite),
        .apb_pwdata       (apb_pwdata),
        .apb_pstrb        (apb_pstrb),
        .apb_pprot        (apb_pprot),
        .apb_prdata       (apb_prdata),
        .apb_pready       (apb_pready),
        .apb_pslverr      (apb_pslverr)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [3:0] size, input logic [3:0] src,
                           input logic [27:0] addr, input logic [3:0] mask,
                           input logic [31:0] data, input logic corrupt);
        tl_a_opcode  = op;
        tl_a_size    = size;
        tl_a_source  = src;
        tl_a_address = addr;
        tl_a_mask    = mask;
        tl_a_data    = data;
        tl_a_corrupt = corrupt;
        tl_a_valid   = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        tl_a_opcode  = 3'd0;
        tl_a_param   = 3'd0;
        tl_a_size    = 4'd0;
        tl_a_source  = '0;
        tl_a_address = '0;
        tl_a_mask    = 4'd0;
        tl_a_data    = 32'h0;
        tl_a_corrupt = 1'b0;
        tl_a_valid   = 1'b0;
        tl_d_ready   = 1'b1;
        apb_prdata   = 32'h0;
        apb_pready   = 1'b0;
        apb_pslverr  = 1'b0;

        // Reset state
        tick;
        tick;
        check_eq("rst_psel", apb_psel, 0);
        check_eq("rst_penable", apb_penable, 0);
        check_eq("rst_d_valid", tl_d_valid, 0);
        check_eq("rst_a_ready", tl_a_ready, 0);
        check_eq("rst_paddr", apb_paddr, 0);
        check_eq("rst_d_data", tl_d_data, 0);
        rst = 1'b0;
        #1;
        check_eq("rel_a_ready", tl_a_ready, 1);

        // Get, minimum latency
        apb_pready = 1'b1;
        apb_prdata = 32'hDEADBEEF;
        drive_a(3'd4, 4'd2, 4'd3, 28'h0000104, 4'hF, 32'h0, 1'b0);
        tick;
        tl_a_valid = 1'b0;
        check_eq("get_setup_psel", apb_psel, 1);
        check_eq("get_setup_penable", apb_penable, 0);
        check_eq("get_paddr", apb_paddr, 28'h0000104);
        check_eq("get_pwrite", apb_pwrite, 0);
        check_eq("get_pstrb", apb_pstrb, 0);
        check_eq("get_pprot", apb_pprot, 0);
        check_eq("get_setup_dvalid", tl_d_valid, 0);
        tick;
        check_eq("get_access_penable", apb_penable, 1);
        check_eq("get_access_dvalid", tl_d_valid, 0);
        tick;
        check_eq("get_d_valid", tl_d_valid, 1);
        check_eq("get_d_opcode", tl_d_opcode, 1);
        check_eq("get_d_data", tl_d_data, 32'hDEADBEEF);
        check_eq("get_d_source", tl_d_source, 3);
        check_eq("get_d_size", tl_d_size, 2);
        check_eq("get_d_param", tl_d_param, 0);
        check_eq("get_d_denied", tl_d_denied, 0);
        check_eq("get_d_corrupt", tl_d_corrupt, 0);
        check_eq("get_resp_psel", apb_psel, 0);
        tick;
        check_eq("get_idle_dvalid", tl_d_valid, 0);
        check_eq("get_idle_aready", tl_a_ready, 1);

        // PutPartial with a slow peripheral
        apb_pready = 1'b0;
        drive_a(3'd1, 4'd2, 4'd5, 28'h0000203, 4'b0110, 32'h12345678, 1'b0);
        tick;
        tl_a_valid = 1'b0;
        check_eq("pp_setup_psel", apb_psel, 1);
        check_eq("pp_setup_penable", apb_penable, 0);
        check_eq("pp_setup_paddr", apb_paddr, 28'h0000200);
        check_eq("pp_setup_pstrb", apb_pstrb, 4'b0110);
        check_eq("pp_setup_pwdata", apb_pwdata, 32'h12345678);
        check_eq("pp_setup_pwrite", apb_pwrite, 1);
        tick;
        for (int i = 1; i <= 6; i++) begin
            check_eq("pp_acc_penable", apb_penable, 1);
            check_eq("pp_acc_psel", apb_psel, 1);
            check_eq("pp_acc_paddr", apb_paddr, 28'h0000200);
            check_eq("pp_acc_pstrb", apb_pstrb, 4'b0110);
            check_eq("pp_acc_pwdata", apb_pwdata, 32'h12345678);
            check_eq("pp_acc_dvalid", tl_d_valid, 0);
            if (i == 6) apb_pready = 1'b1;
            tick;
        end
        apb_pready = 1'b0;
        check_eq("pp_d_valid", tl_d_valid, 1);
        check_eq("pp_d_opcode", tl_d_opcode, 0);
        check_eq("pp_d_denied", tl_d_denied, 0);
        check_eq("pp_d_data", tl_d_data, 0);
        check_eq("pp_d_source", tl_d_source, 5);
        check_eq("pp_d_corrupt", tl_d_corrupt, 0);
        check_eq("pp_resp_psel", apb_psel, 0);
        tick;

        // Get with slave error
        apb_pready  = 1'b1;
        apb_pslverr = 1'b1;
        apb_prdata  = 32'h11112222;
        drive_a(3'd4, 4'd2, 4'd6, 28'h0000010, 4'hF, 32'h0, 1'b0);
        tick;
        tl_a_valid = 1'b0;
        tick;
        tick;
        check_eq("err_d_valid", tl_d_valid, 1);
        check_eq("err_d_opcode", tl_d_opcode, 1);
        check_eq("err_d_denied", tl_d_denied, 1);
        check_eq("err_d_corrupt", tl_d_corrupt, 1);
        apb_pslverr = 1'b0;
        tick;

        // Get size 3: rejected without touching APB
        drive_a(3'd4, 4'd3, 4'd2, 28'h0000020, 4'hF, 32'h0, 1'b0);
        tick;
        tl_a_valid = 1'b0;
        check_eq("sz3_psel", apb_psel, 0);
        check_eq("sz3_d_valid", tl_d_valid, 1);
        check_eq("sz3_d_opcode", tl_d_opcode, 1);
        check_eq("sz3_d_denied", tl_d_denied, 1);
        check_eq("sz3_d_corrupt", tl_d_corrupt, 1);
        check_eq("sz3_d_data", tl_d_data, 0);
        check_eq("sz3_d_size", tl_d_size, 3);
        tick;
        check_eq("sz3_idle_dvalid", tl_d_valid, 0);

        // Unsupported opcode 2
        drive_a(3'd2, 4'd2, 4'd8, 28'h0000030, 4'hF, 32'h0, 1'b0);
        tick;
        tl_a_valid = 1'b0;
        check_eq("op2_psel", apb_psel, 0);
        check_eq("op2_d_valid", tl_d_valid, 1);
        check_eq("op2_d_opcode", tl_d_opcode, 0);
        check_eq("op2_d_denied", tl_d_denied, 1);
        check_eq("op2_d_corrupt", tl_d_corrupt, 0);
        check_eq("op2_d_source", tl_d_source, 8);
        tick;

        // PutFull with corrupt data
        drive_a(3'd0, 4'd2, 4'd1, 28'h0000040, 4'hF, 32'h0, 1'b1);
        tick;
        tl_a_valid = 1'b0;
        check_eq("cor_psel", apb_psel, 0);
        check_eq("cor_d_opcode", tl_d_opcode, 0);
        check_eq("cor_d_denied", tl_d_denied, 1);
        tick;

        // Backpressure on D with a pending second request
        tl_d_ready = 1'b0;
        apb_prdata = 32'hA5A50F0F;
        drive_a(3'd4, 4'd2, 4'd7, 28'h0000300, 4'hF, 32'h0, 1'b0);
        tick;
        drive_a(3'd0, 4'd2, 4'd2, 28'h0000400, 4'hF, 32'hCAFEF00D, 1'b0);
        tick;
        tick;
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_d_valid", tl_d_valid, 1);
            check_eq("bp_d_data", tl_d_data, 32'hA5A50F0F);
            check_eq("bp_d_source", tl_d_source, 7);
            check_eq("bp_d_opcode", tl_d_opcode, 1);
            check_eq("bp_a_ready", tl_a_ready, 0);
            check_eq("bp_psel", apb_psel, 0);
            tick;
        end
        tl_d_ready = 1'b1;
        check_eq("bp_last_dvalid", tl_d_valid, 1);
        check_eq("bp_last_data", tl_d_data, 32'hA5A50F0F);
        tick;
        check_eq("bp_idle_dvalid", tl_d_valid, 0);
        check_eq("bp_idle_aready", tl_a_ready, 1);
        check_eq("bp_idle_psel", apb_psel, 0);
        tick;
        tl_a_valid = 1'b0;
        check_eq("bp2_psel", apb_psel, 1);
        check_eq("bp2_paddr", apb_paddr, 28'h0000400);
        check_eq("bp2_pwrite", apb_pwrite, 1);
        check_eq("bp2_pwdata", apb_pwdata, 32'hCAFEF00D);
        tick;
        tick;
        check_eq("bp2_d_valid", tl_d_valid, 1);
        check_eq("bp2_d_opcode", tl_d_opcode, 0);
        check_eq("bp2_d_source", tl_d_source, 2);
        check_eq("bp2_d_denied", tl_d_denied, 0);
        tick;

        // Reset asserted during ACCESS
        apb_pready = 1'b0;
        drive_a(3'd4, 4'd2, 4'd1, 28'h0000010, 4'hF, 32'h0, 1'b0);
        tick;
        tl_a_valid = 1'b0;
        tick;
        check_eq("mr_penable_before", apb_penable, 1);
        rst = 1'b1;
        #1;
        check_eq("mr_psel", apb_psel, 0);
        check_eq("mr_penable", apb_penable, 0);
        check_eq("mr_d_valid", tl_d_valid, 0);
        check_eq("mr_a_ready", tl_a_ready, 0);
        tick;
        tick;
        rst = 1'b0;
        #1;
        check_eq("mr_rel_aready", tl_a_ready, 1);
        apb_pready = 1'b1;
        apb_prdata = 32'h0BADF00D;
        drive_a(3'd4, 4'd2, 4'd9, 28'h0000020, 4'hF, 32'h0, 1'b0);
        tick;
        tl_a_valid = 1'b0;
        tick;
        tick;
        check_eq("mr2_d_valid", tl_d_valid, 1);
        check_eq("mr2_d_data", tl_d_data, 32'h0BADF00D);
        check_eq("mr2_d_denied", tl_d_denied, 0);
        check_eq("mr2_d_source", tl_d_source, 9);
        tick;

        // Peripheral that never answers
        apb_pready = 1'b0;
        drive_a(3'd4, 4'd2, 4'd4, 28'h0000050, 4'hF, 32'h0, 1'b0);
        tick;
        tl_a_valid = 1'b0;
        tick;
        n = 0;
`ifdef TL2APB_TIMEOUT_EN
        for (int i = 0; i < 40 && !tl_d_valid; i++) begin
            if (apb_penable) n++;
            tick;
        end
        check_eq("to_access_cycles", n, 16);
        check_eq("to_d_valid", tl_d_valid, 1);
        check_eq("to_d_denied", tl_d_denied, 1);
        check_eq("to_d_data", tl_d_data, 0);
        check_eq("to_psel", apb_psel, 0);
        tick;
`else
        for (int i = 0; i < 20; i++) begin
            if (apb_penable) n++;
            tick;
        end
        check_eq("wait_access_cycles", n, 20);
        check_eq("wait_d_valid", tl_d_valid, 0);
        apb_pready = 1'b1;
        apb_prdata = 32'h55AA55AA;
        tick;
        check_eq("wait_d_valid_end", tl_d_valid, 1);
        check_eq("wait_d_data", tl_d_data, 32'h55AA55AA);
        check_eq("wait_d_denied", tl_d_denied, 0);
        tick;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tl_ul_to_apb.md
TL_UL_TO_APB -- requirements
Module: tl_ul_to_apb

Interface
REQ-001 SHALL have parameters: TL_RS, default 4, source width; TL_AW, default 28, address width; TIMEOUT, default 16, max ACCESS cycles when timeout is compiled in (range 2..255).
REQ-002 SHALL have port tilelink_clock_i  in  1  the one clock; all logic on its rising edge.
REQ-003 SHALL have port tilelink_reset_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have TL-UL A inputs tl_a_opcode[2:0], tl_a_param[2:0], tl_a_size[3:0], tl_a_source[TL_RS-1:0], tl_a_address[TL_AW-1:0], tl_a_mask[3:0], tl_a_data[31:0], tl_a_corrupt, tl_a_valid, plus output tl_a_ready  1  request channel from upstream width/burst bridge.
REQ-005 SHALL have TL-UL D outputs tl_d_opcode[2:0], tl_d_param[1:0], tl_d_size[3:0], tl_d_source[TL_RS-1:0], tl_d_denied, tl_d_data[31:0], tl_d_corrupt, tl_d_valid, plus input tl_d_ready  1  response channel.
REQ-006 SHALL have APB outputs apb_paddr[TL_AW-1:0], apb_psel, apb_penable, apb_pwrite, apb_pwdata[31:0], apb_pstrb[3:0], apb_pprot[2:0], plus inputs apb_prdata[31:0], apb_pready, apb_pslverr.

Function
REQ-007 SHALL be a single-outstanding bridge with FSM states IDLE, SETUP, ACCESS, RESP.
REQ-008 SHALL drive tl_a_ready=1 only in IDLE; a beat is accepted when tl_a_valid&tl_a_ready, and all A fields are latched then.
REQ-009 Accepted Get(4), size<=2: SHALL go to SETUP, read. PutFull(0)/PutPartial(1), size<=2: SHALL go to SETUP, write.
REQ-010 Any other opcode, size>2, or tl_a_corrupt=1 on a Put: SHALL skip APB, go directly to RESP with tl_d_denied=1.
REQ-011 SETUP SHALL last exactly one cycle with psel=1, penable=0, then go to ACCESS.
REQ-012 ACCESS SHALL hold psel=1, penable=1 until apb_pready=1; on that cycle it SHALL capture prdata and pslverr, and go to RESP.
REQ-013 paddr/pwrite/pwdata/pstrb SHALL be stable across SETUP and ACCESS. paddr={address[TL_AW-1:2],2'b00}. pstrb=mask for writes, 4'b0000 for reads. pprot=3'b000.
REQ-014 In RESP, tl_d_valid=1 and all D fields SHALL be held until tl_d_ready=1; the state then returns to IDLE with tl_d_valid=0 in the next cycle.
REQ-015 D fields: opcode=1 (AccessAckData) for Get, 0 (AccessAck) otherwise; param=0; size and source echoed from the request.
REQ-016 D fields: denied=pslverr, timeout, or REQ-010 rejection; data=captured prdata for Get, else 0; corrupt=denied&Get.
REQ-017 Minimum latency, accept to tl_d_valid, SHALL be 3 cycles with pready=1 in the first ACCESS cycle. Throughput SHALL be one transfer per 4 cycles when tl_d_ready=1.
REQ-018 psel, penable, tl_d_valid SHALL never assert outside SETUP/ACCESS/RESP respectively.

Reset
REQ-019 Asserting tilelink_reset_i, including mid-transfer, SHALL immediately force IDLE with psel=0, penable=0, tl_d_valid=0, tl_a_ready=0 while reset is held, and all other outputs 0. tl_a_ready=1 the first cycle after release.

Configuration
REQ-020 With TL2APB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on SETUP and increment per ACCESS cycle without pready. On the TIMEOUT-th such cycle it SHALL drop psel/penable and go to RESP with denied=1, data=0. pready arriving on that same cycle SHALL win (normal completion).
REQ-021 Without TL2APB_TIMEOUT_EN: ACCESS SHALL wait indefinitely; no counter logic exists; TIMEOUT is unused.

Verification
REQ-022 Get addr 0x0000104, size 2, source 3; pready=1 first ACCESS, prdata=0xDEADBEEF -> tl_d_valid 3 cycles after accept, opcode 1, data 0xDEADBEEF, source 3, denied 0.
REQ-023 PutPartial addr 0x0000203, mask 4'b0110, data 0x12345678; pready after 5 ACCESS cycles -> paddr 0x0000200, pstrb 0110, pwdata stable for all 6 cycles; then AccessAck, denied 0.
REQ-024 Get with pslverr=1 -> opcode 1, denied 1, corrupt 1. Get size 3 -> no psel pulse, denied 1. Opcode 2 -> no psel, AccessAck denied 1.
REQ-025 tl_d_ready held 0 for 4 cycles in RESP -> D fields unchanged, tl_a_ready=0, new tl_a_valid not accepted until the cycle after tl_d_ready=1.
REQ-026 Reset asserted during ACCESS -> psel/penable low same cycle. Post-release Get completes normally. With TL2APB_TIMEOUT_EN and TIMEOUT=16: pready never -> denied 1 after 16 ACCESS cycles.
